// File: rtl/alu_const_select_seq.sv
// Sequenced constant-select generator: turns a latched op/arg request into one
// (or, for SWEEP, eight) registered one-hot select beats for the constant mux.
module alu_const_select_seq (
  input  logic       Clock,
  input  logic       Reset_n,
  input  logic       Req_Valid,
  output logic       Req_Ready,
  input  logic [2:0] Req_Op,
  input  logic [2:0] Req_Arg,
  input  logic       Flush,
  output logic       Out_Valid,
  input  logic       Out_Ready,
  output logic       Out_Last,
  output logic       PA_Select_0x1_high,
  output logic       PA_Select_0xffOP_low,
  output logic       PA_Select_0x1_low,
  output logic       PA_Select_0x8_low,
  output logic       PA_Select_0x10_low,
  output logic       PA_Select_0x18_low,
  output logic       PA_Select_0x20_low,
  output logic       PA_Select_0x28_low,
  output logic       PA_Select_0x30_low,
  output logic       PA_Select_0x38_low,
  output logic       PA_Select_0x66_low,
  output logic       PA_Select_0x99_low,
  output logic       PA_Select_0x06_low,
  output logic       PA_Select_0x60_low,
  output logic       PA_Select_0x2_low,
  output logic       PA_Select_0x4_low,
  output logic       PA_Select_0x40_low,
  output logic       PA_Select_0x80_low,
  output logic       dbg_state
);

  typedef enum logic {IDLE = 1'b0, OUT = 1'b1} state_t;

  localparam logic [2:0] OP_ZERO  = 3'd0;
  localparam logic [2:0] OP_ONE   = 3'd1;
  localparam logic [2:0] OP_RST   = 3'd2;
  localparam logic [2:0] OP_BIT   = 3'd3;
  localparam logic [2:0] OP_DAA   = 3'd4;
  localparam logic [2:0] OP_PAGE  = 3'd5;
  localparam logic [2:0] OP_SWEEP = 3'd6;
  localparam logic [2:0] OP_HIGH1 = 3'd7;

  // Select vector bit order: 0 0x1_high, 1 0xffOP, 2 0x1, 3 0x8, 4 0x10, 5 0x18,
  // 6 0x20, 7 0x28, 8 0x30, 9 0x38, 10 0x66, 11 0x99, 12 0x06, 13 0x60,
  // 14 0x2, 15 0x4, 16 0x40, 17 0x80.
  function automatic logic [17:0] bit_sel(input logic [2:0] k);
    logic [17:0] s;
    s = '0;
    case (k)
      3'd0: s[2]  = 1'b1;
      3'd1: s[14] = 1'b1;
      3'd2: s[15] = 1'b1;
      3'd3: s[3]  = 1'b1;
      3'd4: s[4]  = 1'b1;
      3'd5: s[6]  = 1'b1;
      3'd6: s[16] = 1'b1;
      default: s[17] = 1'b1;
    endcase
    return s;
  endfunction

  function automatic logic [17:0] decode(input logic [2:0] op, input logic [2:0] arg);
    logic [17:0] s;
    s = '0;
    case (op)
      OP_ZERO: s = '0;
      OP_ONE:  s[2] = 1'b1;
      OP_RST:  if (arg != 3'd0) s[4'(arg) + 4'd2] = 1'b1;
      OP_BIT, OP_SWEEP: s = bit_sel(arg);
      OP_DAA: begin
        case (arg[1:0])
          2'b01: s[12] = 1'b1;
          2'b10: s[13] = 1'b1;
          2'b11: if (arg[2]) s[11] = 1'b1; else s[10] = 1'b1;
          default: s = '0;
        endcase
      end
      OP_PAGE:  s[1] = 1'b1;
      OP_HIGH1: s[0] = 1'b1;
      default:  s = '0;
    endcase
    return s;
  endfunction

  state_t      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d, op_q, op_d, arg_q, arg_d, cnt_inc;
  logic        valid_q, valid_d, last_q, last_d, accept, beat_done;
  logic [17:0] sel_q, sel_d;

  // Handshakes: a request transfers on Req_Valid && Req_Ready, a beat on
  // Out_Valid && Out_Ready; outputs hold while Out_Valid && !Out_Ready, and a
  // new request may land in the same cycle the last beat is taken.
  assign Req_Ready = Reset_n && !Flush && ((state_q == IDLE) || (Out_Ready && last_q));
  assign accept    = Req_Valid && Req_Ready;
  assign beat_done = valid_q && Out_Ready;
  assign cnt_inc   = cnt_q + 3'd1;

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      arg_q   <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      sel_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      arg_q   <= arg_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      sel_q   <= sel_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    arg_d   = arg_q;
    valid_d = valid_q;
    last_d  = last_q;
    sel_d   = sel_q;
    if (Flush) begin
      state_d = IDLE;
      cnt_d   = '0;
      valid_d = 1'b0;
      last_d  = 1'b0;
      sel_d   = '0;
    end else if (accept) begin
      state_d = OUT;
      cnt_d   = '0;
      op_d    = Req_Op;
      arg_d   = Req_Arg;
      valid_d = 1'b1;
      last_d  = (Req_Op != OP_SWEEP);
      sel_d   = decode(Req_Op, Req_Arg);
    end else if (beat_done) begin
      if (last_q) begin
        state_d = IDLE;
        cnt_d   = '0;
        valid_d = 1'b0;
        last_d  = 1'b0;
        sel_d   = '0;
      end else begin
        // SWEEP bit index wraps naturally in 3 bits.
        cnt_d  = cnt_inc;
        sel_d  = bit_sel(3'(arg_q + cnt_inc));
        last_d = (cnt_inc == 3'd7);
      end
    end
  end

  assign Out_Valid            = valid_q;
  assign Out_Last             = last_q;
  assign dbg_state            = state_q;
  assign PA_Select_0x1_high   = sel_q[0];
  assign PA_Select_0xffOP_low = sel_q[1];
  assign PA_Select_0x1_low    = sel_q[2];
  assign PA_Select_0x8_low    = sel_q[3];
  assign PA_Select_0x10_low   = sel_q[4];
  assign PA_Select_0x18_low   = sel_q[5];
  assign PA_Select_0x20_low   = sel_q[6];
  assign PA_Select_0x28_low   = sel_q[7];
  assign PA_Select_0x30_low   = sel_q[8];
  assign PA_Select_0x38_low   = sel_q[9];
  assign PA_Select_0x66_low   = sel_q[10];
  assign PA_Select_0x99_low   = sel_q[11];
  assign PA_Select_0x06_low   = sel_q[12];
  assign PA_Select_0x60_low   = sel_q[13];
  assign PA_Select_0x2_low    = sel_q[14];
  assign PA_Select_0x4_low    = sel_q[15];
  assign PA_Select_0x40_low   = sel_q[16];
  assign PA_Select_0x80_low   = sel_q[17];

endmodule

// File: tb/tb_alu_const_select_seq.sv
// Directed bench for alu_const_select_seq: hand-computed select vectors,
// handshake timing, flush, async reset and a random one-hot sweep.
module tb_alu_const_select_seq;

  logic       Clock = 1'b0;
  logic       Reset_n = 1'b0;
  logic       Req_Valid = 1'b0, Flush = 1'b0, Out_Ready = 1'b0;
  logic [2:0] Req_Op = '0, Req_Arg = '0;
  logic       Req_Ready, Out_Valid, Out_Last, dbg_state;
  logic s1h, sff, s1l, s8, s10, s18, s20, s28, s30, s38, s66, s99, s06, s60, s2, s4, s40, s80;
  logic [17:0] sel;

  int total = 0;
  int bad = 0;

  // Expected one-hot patterns, indexed in the same order as sel below.
  localparam logic [17:0] S_NONE = 18'd0;
  localparam logic [17:0] S_1H = 18'd1 << 0,  S_FF = 18'd1 << 1,  S_1  = 18'd1 << 2;
  localparam logic [17:0] S_8  = 18'd1 << 3,  S_10 = 18'd1 << 4,  S_18 = 18'd1 << 5;
  localparam logic [17:0] S_20 = 18'd1 << 6,  S_28 = 18'd1 << 7,  S_30 = 18'd1 << 8;
  localparam logic [17:0] S_38 = 18'd1 << 9,  S_66 = 18'd1 << 10, S_99 = 18'd1 << 11;
  localparam logic [17:0] S_06 = 18'd1 << 12, S_60 = 18'd1 << 13, S_2  = 18'd1 << 14;
  localparam logic [17:0] S_4  = 18'd1 << 15, S_40 = 18'd1 << 16, S_80 = 18'd1 << 17;

  assign sel = {s80, s40, s4, s2, s60, s06, s99, s66, s38, s30, s28, s20, s18, s10, s8, s1l, sff, s1h};

  alu_const_select_seq dut (
    .Clock(Clock), .Reset_n(Reset_n), .Req_Valid(Req_Valid), .Req_Ready(Req_Ready),
    .Req_Op(Req_Op), .Req_Arg(Req_Arg), .Flush(Flush), .Out_Valid(Out_Valid),
    .Out_Ready(Out_Ready), .Out_Last(Out_Last),
    .PA_Select_0x1_high(s1h), .PA_Select_0xffOP_low(sff), .PA_Select_0x1_low(s1l),
    .PA_Select_0x8_low(s8), .PA_Select_0x10_low(s10), .PA_Select_0x18_low(s18),
    .PA_Select_0x20_low(s20), .PA_Select_0x28_low(s28), .PA_Select_0x30_low(s30),
    .PA_Select_0x38_low(s38), .PA_Select_0x66_low(s66), .PA_Select_0x99_low(s99),
    .PA_Select_0x06_low(s06), .PA_Select_0x60_low(s60), .PA_Select_0x2_low(s2),
    .PA_Select_0x4_low(s4), .PA_Select_0x40_low(s40), .PA_Select_0x80_low(s80),
    .dbg_state(dbg_state)
  );

  always #5 Clock = ~Clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  // Issue one single-beat request with Out_Ready=1 and check the beat and the return to idle.
  task automatic one_beat(input string tag, input logic [2:0] op, input logic [2:0] arg,
                          input logic [17:0] exp_sel);
    Req_Valid = 1'b1; Req_Op = op; Req_Arg = arg; Out_Ready = 1'b1;
    step();
    Req_Valid = 1'b0;
    check({tag, "_valid"}, 32'(Out_Valid), 32'd1);
    check({tag, "_last"},  32'(Out_Last), 32'd1);
    check({tag, "_sel"},   32'(sel), 32'(exp_sel));
    step();
    check({tag, "_idle_valid"}, 32'(Out_Valid), 32'd0);
    check({tag, "_idle_sel"},   32'(sel), 32'(S_NONE));
  endtask

  initial begin
    logic [17:0] sweep_exp [8];
    sweep_exp = '{S_40, S_80, S_1, S_2, S_4, S_8, S_10, S_20};

    // Reset asserted: everything low, including Req_Ready.
    #12;
    check("rst_valid", 32'(Out_Valid), 32'd0);
    check("rst_last",  32'(Out_Last), 32'd0);
    check("rst_sel",   32'(sel), 32'(S_NONE));
    check("rst_ready", 32'(Req_Ready), 32'd0);
    check("rst_state", 32'(dbg_state), 32'd0);
    Reset_n = 1'b1;
    #1;
    check("idle_ready", 32'(Req_Ready), 32'd1);

    // Single-beat classes.
    one_beat("rst5",  3'd2, 3'd5, S_28);
    one_beat("rst0",  3'd2, 3'd0, S_NONE);
    one_beat("rst7",  3'd2, 3'd7, S_38);
    one_beat("rst1",  3'd2, 3'd1, S_8);
    one_beat("zero",  3'd0, 3'd3, S_NONE);
    one_beat("one",   3'd1, 3'd0, S_1);
    one_beat("page",  3'd5, 3'd2, S_FF);
    one_beat("high1", 3'd7, 3'd4, S_1H);
    one_beat("bit0",  3'd3, 3'd0, S_1);
    one_beat("bit5",  3'd3, 3'd5, S_20);
    one_beat("bit7",  3'd3, 3'd7, S_80);
    one_beat("daa1",  3'd4, 3'd1, S_06);
    one_beat("daa6",  3'd4, 3'd6, S_60);
    one_beat("daa4",  3'd4, 3'd4, S_NONE);
    one_beat("daa5",  3'd4, 3'd5, S_06);

    // DAA 3 then DAA 7 back to back.
    Req_Valid = 1'b1; Req_Op = 3'd4; Req_Arg = 3'd3; Out_Ready = 1'b1;
    #1;
    check("b2b_ready0", 32'(Req_Ready), 32'd1);
    step();
    Req_Arg = 3'd7;
    #1;
    check("b2b_sel0",   32'(sel), 32'(S_66));
    check("b2b_ready1", 32'(Req_Ready), 32'd1);
    step();
    Req_Valid = 1'b0;
    check("b2b_sel1",  32'(sel), 32'(S_99));
    check("b2b_last1", 32'(Out_Last), 32'd1);
    step();
    check("b2b_idle", 32'(Out_Valid), 32'd0);

    // SWEEP from 6 with two stall cycles on the first beat; op/arg changes ignored.
    Req_Valid = 1'b1; Req_Op = 3'd6; Req_Arg = 3'd6; Out_Ready = 1'b0;
    step();
    Req_Valid = 1'b0; Req_Op = 3'd1; Req_Arg = 3'd0;
    check("sw_b0_sel",   32'(sel), 32'(S_40));
    check("sw_b0_last",  32'(Out_Last), 32'd0);
    check("sw_b0_ready", 32'(Req_Ready), 32'd0);
    step();
    check("sw_stall1", 32'(sel), 32'(S_40));
    step();
    check("sw_stall2", 32'(sel), 32'(S_40));
    Out_Ready = 1'b1;
    for (int i = 1; i < 8; i++) begin
      step();
      check($sformatf("sw_b%0d_sel", i),  32'(sel), 32'(sweep_exp[i]));
      check($sformatf("sw_b%0d_last", i), 32'(Out_Last), (i == 7) ? 32'd1 : 32'd0);
    end
    step();
    check("sw_end_valid", 32'(Out_Valid), 32'd0);
    check("sw_end_sel",   32'(sel), 32'(S_NONE));

    // Flush on the third SWEEP beat with a competing request.
    Req_Valid = 1'b1; Req_Op = 3'd6; Req_Arg = 3'd0; Out_Ready = 1'b1;
    step();
    Req_Valid = 1'b0;
    check("fl_b1", 32'(sel), 32'(S_1));
    step();
    check("fl_b2", 32'(sel), 32'(S_2));
    step();
    check("fl_b3", 32'(sel), 32'(S_4));
    Flush = 1'b1; Req_Valid = 1'b1; Req_Op = 3'd1; Req_Arg = 3'd0;
    #1;
    check("fl_ready", 32'(Req_Ready), 32'd0);
    step();
    Flush = 1'b0; Req_Valid = 1'b0;
    check("fl_valid", 32'(Out_Valid), 32'd0);
    check("fl_sel",   32'(sel), 32'(S_NONE));
    check("fl_last",  32'(Out_Last), 32'd0);
    check("fl_state", 32'(dbg_state), 32'd0);
    step();
    check("fl_not_accepted", 32'(Out_Valid), 32'd0);

    // Asynchronous reset in the middle of a SWEEP beat.
    Req_Valid = 1'b1; Req_Op = 3'd6; Req_Arg = 3'd2; Out_Ready = 1'b0;
    step();
    Req_Valid = 1'b0;
    check("ar_pre_sel", 32'(sel), 32'(S_4));
    #2;
    Reset_n = 1'b0;
    #1;
    check("ar_valid", 32'(Out_Valid), 32'd0);
    check("ar_sel",   32'(sel), 32'(S_NONE));
    check("ar_last",  32'(Out_Last), 32'd0);
    check("ar_ready", 32'(Req_Ready), 32'd0);
    Reset_n = 1'b1;
    Req_Valid = 1'b1; Req_Op = 3'd1; Req_Arg = 3'd0; Out_Ready = 1'b1;
    #1;
    check("ar_idle_ready", 32'(Req_Ready), 32'd1);
    step();
    Req_Valid = 1'b0;
    check("ar_new_sel", 32'(sel), 32'(S_1));
    step();

    // Random op stream: at most one select high, none while Out_Valid is low.
    for (int n = 0; n < 300; n++) begin
      Req_Valid = 1'($urandom_range(0, 1));
      Req_Op    = 3'($urandom_range(0, 7));
      Req_Arg   = 3'($urandom_range(0, 7));
      Out_Ready = ($urandom_range(0, 3) != 0);
      Flush     = ($urandom_range(0, 19) == 0);
      step();
      check("rnd_onehot", 32'($countones(sel) <= 1), 32'd1);
      if (!Out_Valid) check("rnd_zero_when_idle", 32'(sel), 32'(S_NONE));
    end
    Flush = 1'b0; Req_Valid = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_const_select_seq.md
ALU_CONST_SELECT_SEQ -- requirements
Module: alu_const_select_seq

Interface
REQ-001 Clock  input  1  single system clock; all state updates on rising edge.
REQ-002 Reset_n  input  1  asynchronous, active-low reset; assertion clears state immediately, deassertion takes effect on next Clock edge.
REQ-003 Req_Valid  input  1  upstream request present.
REQ-004 Req_Ready  output  1  block accepts request this cycle; transfer when Req_Valid && Req_Ready.
REQ-005 Req_Op  input  3  constant class: 0 ZERO, 1 ONE, 2 RST, 3 BIT, 4 DAA, 5 PAGE, 6 SWEEP, 7 HIGH1.
REQ-006 Req_Arg  input  3  class argument: RST vector index, bit index, or DAA code.
REQ-007 Flush  input  1  synchronous abort of any request in progress.
REQ-008 Out_Valid  output  1  select outputs hold a valid beat.
REQ-009 Out_Ready  input  1  constant mux consumer takes the beat; transfer when Out_Valid && Out_Ready.
REQ-010 Out_Last  output  1  current beat is the final beat of the request.
REQ-011 PA_Select_0x1_high, PA_Select_0xffOP_low, PA_Select_0x1_low, PA_Select_0x8_low, PA_Select_0x10_low, PA_Select_0x18_low, PA_Select_0x20_low, PA_Select_0x28_low, PA_Select_0x30_low  output  1 each  registered one-hot constant selects.
REQ-012 PA_Select_0x38_low, PA_Select_0x66_low, PA_Select_0x99_low, PA_Select_0x06_low, PA_Select_0x60_low, PA_Select_0x2_low, PA_Select_0x4_low, PA_Select_0x40_low, PA_Select_0x80_low  output  1 each  registered one-hot constant selects.

Function
REQ-013 Two states: IDLE and OUT; 3-bit beat counter; latched op/arg registers.
REQ-014 Req_Ready = !Flush && (IDLE || (OUT && Out_Ready && Out_Last)); back-to-back requests with no bubble.
REQ-015 Latency: request accepted at edge N -> Out_Valid and selects valid after edge N; held stable while Out_Valid && !Out_Ready.
REQ-016 At most one select high at any time; all selects 0 whenever Out_Valid=0.
REQ-017 ZERO: no select high (mux outputs 0); ONE: PA_Select_0x1_low; PAGE: PA_Select_0xffOP_low; HIGH1: PA_Select_0x1_high.
REQ-018 RST: Arg 0 -> no select; Arg 1..7 -> 0x8, 0x10, 0x18, 0x20, 0x28, 0x30, 0x38 selects respectively.
REQ-019 BIT: Arg k -> select for value 1<<k (0x1,0x2,0x4,0x8,0x10,0x20,0x40,0x80 lines).
REQ-020 DAA: Arg[1:0] 00 -> none, 01 -> 0x06, 10 -> 0x60, 11 -> 0x66; Arg=3'b111 -> 0x99 instead of 0x66; Arg[2] otherwise ignored.
REQ-021 All ops except SWEEP: one beat, Out_Last=1.
REQ-022 SWEEP: 8 beats, bit index starts at Arg, increments mod 8 per accepted beat (wrap 7->0); Out_Last=1 on 8th beat only; counter advances only on Out_Valid && Out_Ready.
REQ-023 Final beat accepted with no new request -> IDLE, Out_Valid=0, selects 0 after the edge.
REQ-024 Flush: next edge -> IDLE, Out_Valid=0, counter 0, selects 0; remaining SWEEP beats discarded; Req_Valid in a Flush cycle is not accepted.
REQ-025 Req_Op/Req_Arg changes while not accepted have no effect; latched values used for whole request.

Reset
REQ-026 Reset_n low: state IDLE, counter 0, op/arg 0, Out_Valid=0, Out_Last=0, all 18 selects 0, Req_Ready=0 while asserted.
REQ-027 Reset mid-SWEEP aborts the sequence; first edge after deassertion with Req_Valid=1 accepts a new request (Req_Ready=1 in IDLE).

Verification
REQ-028 RST Arg=5, Out_Ready=1 -> next cycle PA_Select_0x28_low=1, Out_Valid=1, Out_Last=1; following cycle all selects 0.
REQ-029 SWEEP Arg=6, Out_Ready stalled 2 cycles on beat 1 -> beats 0x40,0x80,0x1,0x2,0x4,0x8,0x10,0x20 in order, 0x40 held during stall, Out_Last only on 0x20.
REQ-030 DAA Arg=3 then DAA Arg=7 back-to-back, Out_Ready=1 -> 0x66 then 0x99 on consecutive cycles, Req_Ready=1 both cycles.
REQ-031 Flush asserted on beat 3 of SWEEP with Req_Valid=1 -> Out_Valid=0 next cycle, request not accepted, selects all 0.
REQ-032 Reset_n pulsed low asynchronously mid-beat -> all outputs 0 immediately, no Clock edge required; random op stream checks one-hot invariant.
